// File: rtl/rv64_core_pkg.sv
// rv64_core_pkg: shared core widths, dispatch slot record and popcount helper
package rv64_core_pkg;
  localparam int INSTR_NUM = 4;
  localparam int ISSUE_NUM = 4;
  localparam int OPCODE    = 7;
  localparam int PRF_WIDTH = 6;
  localparam int PRF_NUM   = 2 ** PRF_WIDTH;
  localparam int CIQ_DEPTH = 16;
  localparam int CNT_W     = $clog2(CIQ_DEPTH + 1);
  typedef struct packed {
    logic [OPCODE-1:0]    op;
    logic                 prs1_v;
    logic                 prs2_v;
    logic                 prd_v;
    logic [PRF_WIDTH-1:0] prs1;
    logic [PRF_WIDTH-1:0] prs2;
    logic [PRF_WIDTH-1:0] prd;
  } slot_t;
  function automatic logic [CNT_W-1:0] popcount(input logic [INSTR_NUM-1:0] v);
    popcount = '0;
    for (int i = 0; i < INSTR_NUM; i++) popcount += CNT_W'(v[i]);
  endfunction
endpackage

// File: rtl/dispatch_stage_if.sv
// dispatch_stage_if: rename-side group, CIQ write side and wakeup broadcast bundle
interface dispatch_stage_if;
  import rv64_core_pkg::*;
  logic                           flush;
  logic [INSTR_NUM-1:0]           in_valid;
  logic                           in_ready;
  logic [INSTR_NUM*OPCODE-1:0]    in_op;
  logic [INSTR_NUM-1:0]           in_prs1_v, in_prs2_v, in_prd_v;
  logic [INSTR_NUM*PRF_WIDTH-1:0] in_prs1, in_prs2, in_prd;
  logic [CNT_W-1:0]               ciq_free_cnt;
  logic [ISSUE_NUM-1:0]           wk_valid;
  logic [ISSUE_NUM*PRF_WIDTH-1:0] wk_prd;
  logic [INSTR_NUM-1:0]           out_valid;
  logic [INSTR_NUM*OPCODE-1:0]    out_op;
  logic [INSTR_NUM-1:0]           out_prs1_v, out_prs2_v, out_prd_v;
  logic [INSTR_NUM*PRF_WIDTH-1:0] out_prs1, out_prs2, out_prd;
  logic [INSTR_NUM-1:0]           out_prs1_rdy, out_prs2_rdy;
  modport master (
    output flush, in_valid, in_op, in_prs1_v, in_prs2_v, in_prd_v, in_prs1, in_prs2, in_prd,
           ciq_free_cnt, wk_valid, wk_prd,
    input  in_ready, out_valid, out_op, out_prs1_v, out_prs2_v, out_prd_v, out_prs1, out_prs2,
           out_prd, out_prs1_rdy, out_prs2_rdy
  );
  modport slave (
    input  flush, in_valid, in_op, in_prs1_v, in_prs2_v, in_prd_v, in_prs1, in_prs2, in_prd,
           ciq_free_cnt, wk_valid, wk_prd,
    output in_ready, out_valid, out_op, out_prs1_v, out_prs2_v, out_prd_v, out_prs1, out_prs2,
           out_prd, out_prs1_rdy, out_prs2_rdy
  );
endinterface

// File: rtl/busy_table.sv
// busy_table: per-preg busy bits; set wins over clear, preg 0 never busy
module busy_table
  import rv64_core_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr_all_i,
  input  logic [INSTR_NUM-1:0]                 set_v_i,
  input  logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]  set_idx_i,
  input  logic [ISSUE_NUM-1:0]                 clr_v_i,
  input  logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]  clr_idx_i,
  input  logic [2*INSTR_NUM-1:0][PRF_WIDTH-1:0] rd_idx_i,
  output logic [2*INSTR_NUM-1:0]               rd_busy_o
);
  logic [PRF_NUM-1:0] busy_q, busy_d;
  // wakeup clears first, then dispatch sets so a same-cycle set survives
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < ISSUE_NUM; k++) if (clr_v_i[k]) busy_d[clr_idx_i[k]] = 1'b0;
    for (int i = 0; i < INSTR_NUM; i++) if (set_v_i[i]) busy_d[set_idx_i[i]] = 1'b1;
    busy_d[0] = 1'b0;
    busy_d = clr_all_i ? '0 : busy_d;
  end
  // busy bit register
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  // source lookups
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < 2 * INSTR_NUM; k++) rd_busy_o[k] = busy_q[rd_idx_i[k]];
  end
endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage: rename-to-CIQ group register with busy lookup; DISPATCH_WAKEUP_BYPASS_EN enables wakeup bypass
module dispatch_stage
  import rv64_core_pkg::*;
(
  input logic             clk,
  input logic             rst,
  dispatch_stage_if.slave bus
);
  slot_t [INSTR_NUM-1:0]                 slot_q, slot_d, in_slot;
  logic [INSTR_NUM-1:0]                  vld_q, vld_d, set_v;
  logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   set_idx;
  logic [2*INSTR_NUM-1:0][PRF_WIDTH-1:0] rd_idx;
  logic [2*INSTR_NUM-1:0]                rd_busy, rdy;
  logic [CNT_W-1:0]                      need;
  logic                                  fire, accept, hold;
  // unpack incoming group, drive held group and lookup indices
  always_comb begin
    in_slot = '0;
    rd_idx = '0;
    set_idx = '0;
    bus.out_op = '0;
    bus.out_prs1 = '0;
    bus.out_prs2 = '0;
    bus.out_prd = '0;
    bus.out_prs1_rdy = '0;
    bus.out_prs2_rdy = '0;
    for (int i = 0; i < INSTR_NUM; i++) begin
      in_slot[i] = '{op: bus.in_op[i*OPCODE +: OPCODE], prs1_v: bus.in_prs1_v[i], prs2_v: bus.in_prs2_v[i],
                     prd_v: bus.in_prd_v[i], prs1: bus.in_prs1[i*PRF_WIDTH +: PRF_WIDTH],
                     prs2: bus.in_prs2[i*PRF_WIDTH +: PRF_WIDTH], prd: bus.in_prd[i*PRF_WIDTH +: PRF_WIDTH]};
      rd_idx[2*i] = slot_q[i].prs1;
      rd_idx[2*i+1] = slot_q[i].prs2;
      set_idx[i] = slot_q[i].prd;
      bus.out_op[i*OPCODE +: OPCODE] = slot_q[i].op;
      bus.out_prs1[i*PRF_WIDTH +: PRF_WIDTH] = slot_q[i].prs1;
      bus.out_prs2[i*PRF_WIDTH +: PRF_WIDTH] = slot_q[i].prs2;
      bus.out_prd[i*PRF_WIDTH +: PRF_WIDTH] = slot_q[i].prd;
      bus.out_prs1_v[i] = slot_q[i].prs1_v;
      bus.out_prs2_v[i] = slot_q[i].prs2_v;
      bus.out_prd_v[i] = slot_q[i].prd_v;
      bus.out_prs1_rdy[i] = rdy[2*i];
      bus.out_prs2_rdy[i] = rdy[2*i+1];
    end
  end
  // source readiness: intra-group RAW beats busy and bypass; p0 is always ready
  always_comb begin
    hold = 1'b0;
    rdy = '0;
    for (int j = 0; j < INSTR_NUM; j++)
      for (int s = 0; s < 2; s++) begin
        logic v, intra, wk;
        logic [PRF_WIDTH-1:0] p;
        v = s[0] ? slot_q[j].prs2_v : slot_q[j].prs1_v;
        p = s[0] ? slot_q[j].prs2 : slot_q[j].prs1;
        intra = 1'b0;
        wk = 1'b0;
        for (int i = 0; i < j; i++) intra |= vld_q[i] & slot_q[i].prd_v & (slot_q[i].prd == p) & (p != '0);
        for (int k = 0; k < ISSUE_NUM; k++) wk |= bus.wk_valid[k] & (bus.wk_prd[k*PRF_WIDTH +: PRF_WIDTH] == p);
`ifdef DISPATCH_WAKEUP_BYPASS_EN
        rdy[2*j+s] = ~v | (~intra & (~rd_busy[2*j+s] | wk));
`else
        rdy[2*j+s] = ~v | (~intra & ~rd_busy[2*j+s]);
        hold |= vld_q[j] & v & ~intra & wk & (p != '0);
`endif
      end
  end
  // handshake: all-or-nothing CIQ write, refill on the firing cycle
  always_comb begin
    need = popcount(vld_q);
    fire = |vld_q & (bus.ciq_free_cnt >= need) & ~bus.flush & ~hold;
    bus.in_ready = ~bus.flush & (~|vld_q | fire);
    bus.out_valid = fire ? vld_q : '0;
    accept = bus.in_ready & |bus.in_valid;
    vld_d = bus.flush ? '0 : accept ? bus.in_valid : fire ? '0 : vld_q;
    slot_d = accept ? in_slot : slot_q;
    set_v = fire ? vld_q & bus.out_prd_v : '0;
  end
  // stage registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= '0;
      slot_q <= '0;
    end else begin
      vld_q <= vld_d;
      slot_q <= slot_d;
    end
  busy_table u_busy (
    .clk       (clk),
    .rst       (rst),
    .clr_all_i (bus.flush),
    .set_v_i   (set_v),
    .set_idx_i (set_idx),
    .clr_v_i   (bus.wk_valid),
    .clr_idx_i (bus.wk_prd),
    .rd_idx_i  (rd_idx),
    .rd_busy_o (rd_busy)
  );
endmodule
